// File: rtl/sort_stream_ctrl.sv
// sort_stream_ctrl: sequential front/back end for the max-extraction sort stage.
// Loads a frame of M words into the chi register and drives chi to an external
// combinational sort_stage. Each SORT step captures the stage's current max and
// the chi image with that max removed. The M maxima leave as a descending stream.
//
// Handshake semantics: a word moves on a rising edge only when its valid and
// ready are both high. The input side (i_valid/o_ready) accepts only while
// loading. The output side (o_valid/i_ready) holds o_data and o_last stable
// until consumed. The two sides never overlap, so o_ready is low whenever
// o_busy is high.
//
// Optional feature macro: SORT_LAST_CHK_EN adds the i_last input and the
// o_frame_err output. i_last lets a frame close early; the remaining rows are
// zero-filled. o_frame_err pulses on any framing disagreement between i_last
// and the word count.
module sort_stream_ctrl #(
  parameter int M = 8,
  parameter int N = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [N-1:0]          i_data,
`ifdef SORT_LAST_CHK_EN
  input  logic                  i_last,
  output logic                  o_frame_err,
`endif
  output logic [M-1:0][N-1:0]   o_stage_chi,
  input  logic [M-1:0][N-1:0]   i_stage_chi,
  input  logic [N-1:0]          i_stage_y_q,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [N-1:0]          o_data,
  output logic                  o_last,
  output logic                  o_busy
);

  localparam int CW = $clog2(M + 1);
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SORT = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [M-1:0][N-1:0]   chi_q, chi_d;
  logic [N-1:0]          data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
`ifdef SORT_LAST_CHK_EN
  logic                  frame_err_q, frame_err_d;
`endif

  // State register plus the chi and output registers; async reset discards any frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      chi_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
`ifdef SORT_LAST_CHK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chi_q       <= chi_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
`ifdef SORT_LAST_CHK_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  // Next state: load rows by count, then alternate SORT/EMIT once per output word.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    chi_d       = chi_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
`ifdef SORT_LAST_CHK_EN
    frame_err_d = 1'b0;
`endif
    case (state_q)
      ST_LOAD: begin
        if (i_valid) begin
          chi_d[cnt_q[IW-1:0]] = i_data;
`ifdef SORT_LAST_CHK_EN
          if (i_last || (cnt_q == CNT_LAST)) begin
            // An early close zero-fills the rows that were never written.
            for (int i = 0; i < M; i++) begin
              if (i > int'(cnt_q)) chi_d[i] = '0;
            end
            frame_err_d = (cnt_q == CNT_LAST) ? !i_last : i_last;
            cnt_d       = '0;
            state_d     = ST_SORT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`else
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_SORT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end
      end
      ST_SORT: begin
        data_d  = i_stage_y_q;
        chi_d   = i_stage_chi;
        valid_d = 1'b1;
        last_d  = (cnt_q == CNT_LAST);
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (i_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            chi_d   = '0;
            state_d = ST_LOAD;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = ST_SORT;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  assign o_ready     = (state_q == ST_LOAD);
  assign o_busy      = (state_q != ST_LOAD);
  assign o_stage_chi = chi_q;
  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_last      = last_q;
`ifdef SORT_LAST_CHK_EN
  assign o_frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Testbench for sort_stream_ctrl with M=4, N=8. A small combinational
// max-extraction model stands in for sort_stage. Expected output per frame is
// the loaded words sorted descending, which is held in a scoreboard queue.
module tb_sort_stream_ctrl;

  localparam int M = 4;
  localparam int N = 8;

  typedef logic [N-1:0] frame_t [M];

  logic                clk;
  logic                rst;
  logic                i_valid;
  logic                o_ready;
  logic [N-1:0]        i_data;
  logic [M-1:0][N-1:0] stage_chi_out;
  logic [M-1:0][N-1:0] stage_chi_in;
  logic [N-1:0]        stage_y;
  logic                o_valid;
  logic                i_ready;
  logic [N-1:0]        o_data;
  logic                o_last;
  logic                o_busy;
`ifdef SORT_LAST_CHK_EN
  logic                i_last;
  logic                o_frame_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int out_idx  = 0;
  int stage_mi;
  logic [N-1:0] exp_q[$];

  sort_stream_ctrl #(.M(M), .N(N)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
`ifdef SORT_LAST_CHK_EN
    .i_last      (i_last),
    .o_frame_err (o_frame_err),
`endif
    .o_stage_chi (stage_chi_out),
    .i_stage_chi (stage_chi_in),
    .i_stage_y_q (stage_y),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_last      (o_last),
    .o_busy      (o_busy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stand-in sort_stage: report the largest row and clear one copy of it.
  always_comb begin
    stage_mi = 0;
    for (int k = 1; k < M; k++) begin
      if (stage_chi_out[k] > stage_chi_out[stage_mi]) stage_mi = k;
    end
    stage_y      = stage_chi_out[stage_mi];
    stage_chi_in = stage_chi_out;
    stage_chi_in[stage_mi] = '0;
  end

  // Scoreboard helpers
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_expected(input frame_t w);
    logic [N-1:0] a [M];
    logic [N-1:0] t;
    a = w;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < M - 1 - i; j++) begin
        if (a[j] < a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
      end
    end
    for (int i = 0; i < M; i++) exp_q.push_back(a[i]);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Driver: feed one frame; optionally leave i_valid high with the next word.
  task automatic load_frame(input frame_t w, input bit keep_valid, input logic [N-1:0] next_word);
    int n;
    for (int idx = 0; idx < M; idx++) begin
      i_valid = 1'b1;
      i_data  = w[idx];
`ifdef SORT_LAST_CHK_EN
      i_last  = (idx == M - 1);
`endif
      n = 0;
      while (o_ready !== 1'b1 && n < 40) begin tick(); n++; end
      check("load_ready", o_ready, 1'b1);
      tick();
    end
    if (keep_valid) i_data = next_word;
    else i_valid = 1'b0;
`ifdef SORT_LAST_CHK_EN
    i_last = 1'b0;
    check("frame_err_quiet", o_frame_err, 1'b0);
`endif
    push_expected(w);
    check("sort_valid_low", o_valid, 1'b0);
    check("sort_ready_low", o_ready, 1'b0);
    check("sort_busy", o_busy, 1'b1);
    tick();
    check("first_valid_latency", o_valid, 1'b1);
  endtask

  // Driver/monitor: consume n words; stall 0=none, 1=every word, 2=random.
  task automatic collect_words(input int n_words, input int stall);
    int n;
    logic [N-1:0] exp;
    logic [N-1:0] held;
    for (int i = 0; i < n_words; i++) begin
      n = 0;
      while (o_valid !== 1'b1 && n < 40) begin tick(); n++; end
      check("out_valid", o_valid, 1'b1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("out_data", o_data, exp);
      check("out_last", o_last, (out_idx == M - 1));
      check("busy_no_load", o_ready, 1'b0);
      if (stall == 1 || (stall == 2 && $urandom_range(0, 1) == 1)) begin
        held = o_data;
        repeat ($urandom_range(1, 3)) tick();
        check("stall_data", o_data, held);
        check("stall_valid", o_valid, 1'b1);
        check("stall_last", o_last, (out_idx == M - 1));
      end
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check("valid_drop", o_valid, 1'b0);
      if (out_idx == M - 1) begin
        out_idx = 0;
        check("ready_back", o_ready, 1'b1);
        check("idle_busy", o_busy, 1'b0);
        check("chi_cleared", stage_chi_out, '0);
      end else begin
        out_idx++;
      end
    end
  endtask

  frame_t fa, fb;

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b0;
`ifdef SORT_LAST_CHK_EN
    i_last  = 1'b0;
`endif
    #12;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_ready", o_ready, 1'b1);
    check("rst_valid", o_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_data", o_data, '0);
    check("rst_last", o_last, 1'b0);
    check("rst_chi", stage_chi_out, '0);
`ifdef SORT_LAST_CHK_EN
    check("rst_frame_err", o_frame_err, 1'b0);
`endif

    // Basic descending order
    fa = '{8'd3, 8'd9, 8'd1, 8'd7};
    load_frame(fa, 1'b0, '0);
    collect_words(M, 0);

    // Duplicates preserved
    fa = '{8'd5, 8'd5, 8'd2, 8'd5};
    load_frame(fa, 1'b0, '0);
    collect_words(M, 0);

    // Stalled consumer, extreme values
    fa = '{8'hFF, 8'h00, 8'h80, 8'h01};
    load_frame(fa, 1'b0, '0);
    collect_words(M, 1);

    // Async reset in the middle of emission
    fa = '{8'd10, 8'd20, 8'd30, 8'd40};
    load_frame(fa, 1'b0, '0);
    collect_words(2, 0);
    tick();
    check("pre_rst_valid", o_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", o_valid, 1'b0);
    check("async_rst_busy", o_busy, 1'b0);
    check("async_rst_chi", stage_chi_out, '0);
    exp_q.delete();
    out_idx = 0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    fa = '{8'd4, 8'd3, 8'd2, 8'd1};
    load_frame(fa, 1'b0, '0);
    collect_words(M, 0);

    // Back-to-back frames with i_valid held high
    fa = '{8'd11, 8'd99, 8'd42, 8'd0};
    fb = '{8'd7, 8'd200, 8'd7, 8'd13};
    load_frame(fa, 1'b1, fb[0]);
    collect_words(M, 2);
    load_frame(fb, 1'b0, '0);
    collect_words(M, 0);

    // Random frames with random consumer stalls
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < M; k++) fa[k] = N'($urandom_range(0, 255));
      load_frame(fa, 1'b0, '0);
      collect_words(M, 2);
    end

`ifdef SORT_LAST_CHK_EN
    // Early frame close with i_last on the second word
    i_valid = 1'b1; i_data = 8'd6; i_last = 1'b0;
    tick();
    i_data = 8'd8; i_last = 1'b1;
    tick();
    i_valid = 1'b0; i_last = 1'b0;
    check("early_frame_err", o_frame_err, 1'b1);
    fa = '{8'd6, 8'd8, 8'd0, 8'd0};
    push_expected(fa);
    tick();
    check("frame_err_pulse", o_frame_err, 1'b0);
    collect_words(M, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
